// File: rtl/fetch_sequencer.sv
// PC owner and fetch controller for the two-stage core: redirects, stalls and halt/step/resume debug.
// Optional retire counter is built when FETCH_SEQ_RETIRE_CNT_EN is defined.
module fetch_sequencer #(
  parameter int unsigned           ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_EX,
  input  logic [ADDR_W-1:0] target_EX,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              resume_req,
  output logic [ADDR_W-1:0] pc_F,
  output logic              inst_valid_EX,
  output logic              halted,
  output logic [31:0]       retire_count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALTED,
    S_STEP
  } state_e;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              redirect_ok;
  logic [ADDR_W-1:0] pc_inc;

  // A redirect from a bubble slot is not a real instruction and must not steer fetch.
  assign redirect_ok = redirect_EX & valid_q;
  assign pc_inc      = pc_q + PC_ONE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    unique case (state_q)
      S_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            // Hold the un-executed fetch so it is re-fetched when leaving HALTED.
            state_d = S_HALTED;
            valid_d = 1'b0;
            if (redirect_ok) pc_d = target_EX;
          end else if (redirect_ok) begin
            pc_d    = target_EX;
            valid_d = 1'b0;
          end else begin
            pc_d    = pc_inc;
            valid_d = 1'b1;
          end
        end
      end
      S_HALTED: begin
        valid_d = 1'b0;
        if (resume_req) begin
          state_d = S_RUN;
          pc_d    = pc_inc;
          valid_d = 1'b1;
        end else if (step_req) begin
          state_d = S_STEP;
          pc_d    = pc_inc;
          valid_d = 1'b1;
        end
      end
      S_STEP: begin
        if (!stall) begin
          state_d = S_HALTED;
          valid_d = 1'b0;
          if (redirect_ok) pc_d = target_EX;
        end
      end
      default: begin
        state_d = S_RUN;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_F          = pc_q;
  assign inst_valid_EX = valid_q;
  assign halted        = (state_q == S_HALTED);

`ifdef FETCH_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (valid_q && !stall) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`else
  assign retire_count = '0;
`endif

endmodule
